// File: rtl/parser_pkg.sv
`default_nettype none
// ============================================================================
// parser_pkg : shared widths, rule/lookup types and helpers for parser layers
// Rev 1.0
// ============================================================================
package parser_pkg;

    localparam int HEAD_WIDTH       = 512;
    localparam int META_WIDTH       = 512;
    localparam int TAG_WIDTH        = 9;
    localparam int KEY_FILED_NUM    = 8;
    localparam int TYPE_NUM         = 2;
    localparam int DEF_RULE_NUM     = 8;
    localparam int DEPARSER_LATENCY = 3;

    localparam int TYPE_OFF_WIDTH   = $clog2(HEAD_WIDTH / 8);
    localparam int HEAD_WORD_WIDTH  = $clog2(HEAD_WIDTH / 16);
    localparam int META_WORD_WIDTH  = $clog2(META_WIDTH / 16);
    localparam int META_SHIFT_WIDTH = $clog2(META_WIDTH / 16) + 1;
    localparam int HEAD_SHIFT_WIDTH = 7;

    typedef struct packed {
        logic                                             typeRule_valid;
        logic [TYPE_NUM-1:0][TYPE_OFF_WIDTH-1:0]          typeOffset;
        logic [TYPE_NUM-1:0][7:0]                         typeData;
        logic [TYPE_NUM-1:0][7:0]                         typeMask;
        logic [KEY_FILED_NUM-1:0]                         keyOffset_v;
        logic [KEY_FILED_NUM-1:0][META_WORD_WIDTH-1:0]    keyOffset;
        logic [KEY_FILED_NUM-1:0][HEAD_WORD_WIDTH-1:0]    keyReplaceOffset;
        logic [META_SHIFT_WIDTH-1:0]                      metaShift;
        logic [HEAD_SHIFT_WIDTH-1:0]                      headShift;
    } type_rule_t;

    typedef struct packed {
        logic [KEY_FILED_NUM-1:0]                         keyOffset_v;
        logic [KEY_FILED_NUM-1:0][META_WORD_WIDTH-1:0]    keyOffset;
        logic [KEY_FILED_NUM-1:0][HEAD_WORD_WIDTH-1:0]    keyReplaceOffset;
        logic [META_SHIFT_WIDTH-1:0]                      metaShift;
        logic [HEAD_SHIFT_WIDTH-1:0]                      headShift;
    } lookup_rst_t;

    typedef struct packed {
        logic [HEAD_SHIFT_WIDTH-1:0] head_shift;
        logic                        rule_miss;
    } deparser_layer_info_t;

    // Masked compare of both type bytes; bytes are numbered MSB-first.
    function automatic logic type_match(input type_rule_t r, input logic [HEAD_WIDTH-1:0] h);
        logic       ok;
        logic [7:0] b;
        ok = r.typeRule_valid;
        for (int t = 0; t < TYPE_NUM; t++) begin
            b = h[HEAD_WIDTH-1-8*int'(r.typeOffset[t]) -: 8];
            if ((b & r.typeMask[t]) != (r.typeData[t] & r.typeMask[t])) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/deparser_rule_match.sv
`default_nettype none
// ============================================================================
// deparser_rule_match : rule table plus parallel match / lowest-index priority
// Rev 1.0
// ============================================================================
module deparser_rule_match
    import parser_pkg::*;
#(
    parameter int RULE_NUM   = DEF_RULE_NUM,
    parameter int ADDR_WIDTH = $clog2(RULE_NUM)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  adv,
    input  logic [HEAD_WIDTH-1:0] head,
    input  logic                  rule_wren,
    input  logic [ADDR_WIDTH-1:0] rule_addr,
    input  type_rule_t            rule,
    output lookup_rst_t           lookup,
    output logic                  hit
);

    type_rule_t rule_table [RULE_NUM];
    type_rule_t sel_rule;
    logic       sel_found;

    // Table writes ignore the stall so configuration never waits on traffic.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RULE_NUM; i++) begin
                rule_table[i] <= '0;
            end
        end else if (rule_wren && (int'(rule_addr) < RULE_NUM)) begin
            rule_table[rule_addr] <= rule;
        end
    end

    always_comb begin
        sel_found = 1'b0;
        sel_rule  = '0;
        for (int i = 0; i < RULE_NUM; i++) begin
            if (!sel_found && type_match(rule_table[i], head)) begin
                sel_found = 1'b1;
                sel_rule  = rule_table[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lookup <= '0;
            hit    <= 1'b0;
        end else if (adv) begin
            hit                     <= sel_found;
            lookup.keyOffset_v      <= sel_rule.keyOffset_v;
            lookup.keyOffset        <= sel_rule.keyOffset;
            lookup.keyReplaceOffset <= sel_rule.keyReplaceOffset;
            lookup.metaShift        <= sel_rule.metaShift;
            lookup.headShift        <= sel_rule.headShift;
        end
    end

endmodule
`default_nettype wire

// File: rtl/deparser_layer.sv
`default_nettype none
// ============================================================================
// deparser_layer : 3-stage head rewrite / meta shift; DEPARSER_STATS_EN adds counters
// Rev 1.0
// ============================================================================
module deparser_layer
    import parser_pkg::*;
#(
    parameter int LAYER_ID = 0,
    parameter int RULE_NUM = DEF_RULE_NUM
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_valid,
    output logic                              o_ready,
    input  logic [HEAD_WIDTH+TAG_WIDTH-1:0]   i_head,
    input  logic [META_WIDTH+TAG_WIDTH-1:0]   i_meta,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic [HEAD_WIDTH+TAG_WIDTH-1:0]   o_head,
    output logic [META_WIDTH+TAG_WIDTH-1:0]   o_meta,
    output logic [HEAD_SHIFT_WIDTH-1:0]       o_head_shift,
    output logic                              o_rule_miss,
    input  logic                              i_rule_wren,
    input  logic [$clog2(RULE_NUM)-1:0]       i_rule_addr,
    input  logic [$bits(type_rule_t)-1:0]     i_rule
`ifdef DEPARSER_STATS_EN
    ,
    input  logic                              i_cnt_clr,
    output logic [31:0]                       o_hit_cnt,
    output logic [31:0]                       o_miss_cnt
`endif
);

    if (LAYER_ID < 0 || LAYER_ID > 3) begin : g_layer_id_check
        $error("deparser_layer: LAYER_ID must be 0..3");
    end

    logic                            adv;
    logic                            s0_valid, s1_valid;
    logic [HEAD_WIDTH+TAG_WIDTH-1:0] s0_head, s1_head;
    logic [META_WIDTH+TAG_WIDTH-1:0] s0_meta, s1_meta;
    lookup_rst_t                     s1_lookup;
    logic                            s1_hit;
    logic [HEAD_WIDTH-1:0]           head_data, new_head;
    logic [META_WIDTH-1:0]           meta_data, new_meta;
    logic [HEAD_SHIFT_WIDTH-1:0]     new_shift;

    assign adv     = !o_valid || i_ready;
    assign o_ready = adv;

    deparser_rule_match #(
        .RULE_NUM   (RULE_NUM),
        .ADDR_WIDTH ($clog2(RULE_NUM))
    ) u_match (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .adv       (adv),
        .head      (s0_head[TAG_WIDTH +: HEAD_WIDTH]),
        .rule_wren (i_rule_wren),
        .rule_addr (i_rule_addr),
        .rule      (type_rule_t'(i_rule)),
        .lookup    (s1_lookup),
        .hit       (s1_hit)
    );

    assign head_data = s1_head[TAG_WIDTH +: HEAD_WIDTH];
    assign meta_data = s1_meta[TAG_WIDTH +: META_WIDTH];

    // Ascending key order: a later key wins on a duplicate destination word.
    always_comb begin
        new_head  = head_data;
        new_meta  = meta_data;
        new_shift = '0;
        if (s1_hit) begin
            for (int k = 0; k < KEY_FILED_NUM; k++) begin
                if (s1_lookup.keyOffset_v[k]) begin
                    new_head[HEAD_WIDTH-1-16*int'(s1_lookup.keyReplaceOffset[k]) -: 16] =
                        meta_data[META_WIDTH-1-16*int'(s1_lookup.keyOffset[k]) -: 16];
                end
            end
            new_meta  = meta_data << (16 * int'(s1_lookup.metaShift));
            new_shift = s1_lookup.headShift;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s0_valid     <= 1'b0;
            s0_head      <= '0;
            s0_meta      <= '0;
            s1_valid     <= 1'b0;
            s1_head      <= '0;
            s1_meta      <= '0;
            o_valid      <= 1'b0;
            o_head       <= '0;
            o_meta       <= '0;
            o_head_shift <= '0;
            o_rule_miss  <= 1'b0;
        end else if (adv) begin
            s0_valid     <= i_valid;
            s0_head      <= i_head;
            s0_meta      <= i_meta;
            s1_valid     <= s0_valid;
            s1_head      <= s0_head;
            s1_meta      <= s0_meta;
            o_valid      <= s1_valid;
            o_head       <= {new_head, s1_head[TAG_WIDTH-1:0]};
            o_meta       <= {new_meta, s1_meta[TAG_WIDTH-1:0]};
            o_head_shift <= new_shift;
            o_rule_miss  <= s1_valid && !s1_hit;
        end
    end

`ifdef DEPARSER_STATS_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_cnt_clr) begin
            o_hit_cnt  <= '0;
            o_miss_cnt <= '0;
        end else if (o_valid && i_ready) begin
            if (o_rule_miss) begin
                if (o_miss_cnt != 32'hFFFF_FFFF) o_miss_cnt <= o_miss_cnt + 32'd1;
            end else begin
                if (o_hit_cnt != 32'hFFFF_FFFF) o_hit_cnt <= o_hit_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
